mfp_uart_rx_param: RTL
======================

MFP_UART_RX_PARAM -- requirements
Module: mfp_uart_rx_param

Interface
REQ-001 SHALL have parameter CLOCK_FREQUENCY, default 50000000, meaning the clock rate in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, meaning the line rate in bits/s.
REQ-003 SHALL have parameter DATA_BITS, default 8, legal range 5..9, meaning the data bits per frame.
REQ-004 SHALL have parameter STOP_BITS, default 1, legal values 1 or 2, meaning the stop bits checked per frame.
REQ-005 SHALL have parameter FIFO_DEPTH, default 8, a power of 2 and at least 2, meaning the receive FIFO entries.
REQ-006 SHALL have these ports:
- clock  in  1  sole clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- rx  in  1  asynchronous serial line, idle high.
- rd_data  out  DATA_BITS  FIFO head, LSB = first received bit.
- rd_valid  out  1  FIFO not empty.
- rd_ready  in  1  pop FIFO head when rd_valid is high.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  number of occupied FIFO entries.
- framing_error  out  1  one-cycle pulse: a stop bit sampled low.
- break_detect  out  1  one-cycle pulse: all data bits and the first stop bit sampled low.
- overrun  out  1  one-cycle pulse: a frame was dropped because the FIFO was full.
- parity_odd  in  1  parity select: 1 = odd, 0 = even (present only with the macro in REQ-023).
- parity_error  out  1  one-cycle pulse: parity mismatch (present only with the macro in REQ-023).

Function
REQ-007 SHALL pass rx through a 2-flop synchroniser whose flops reset to 1.
REQ-008 SHALL generate a 16x oversample tick every DIV = CLOCK_FREQUENCY/(BAUD_RATE*16) clocks, truncating the division.
- The divider free-runs in IDLE.
- The divider restarts at 0 on the detected start edge.
REQ-009 SHALL implement the state machine IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
REQ-010 SHALL leave IDLE on a 1->0 transition of the synchronised rx.
REQ-011 SHALL take every bit value as the 2-of-3 majority of oversample ticks 7, 8 and 9 of that bit period.
REQ-012 SHALL validate the start bit in START: a start-bit majority of 1 returns the state machine to IDLE with no output (glitch rejection).
REQ-013 SHALL shift DATA_BITS bits into DATA LSB-first.
REQ-014 SHALL sample STOP_BITS stop bits in STOP.
- Any stop bit sampled 0 raises framing_error.
- Framing checking stops at the first stop bit sampled 0.
REQ-015 SHALL raise break_detect together with framing_error when every data bit and the first stop bit are 0.
- A break frame is not written to the FIFO.
- After a break, the state machine waits in IDLE for rx=1 before it re-arms edge detection.
REQ-016 SHALL write a completed, non-break frame at tick 9 of its last stop bit.
- framing_error and parity_error are issued in the same cycle as this write.
- The frame is written even when it carries a framing or parity error.
REQ-017 SHALL raise rd_valid on the clock after a FIFO write that makes the FIFO non-empty.
REQ-018 SHALL drop a frame that finds the FIFO full and pulse overrun, except that a pop in the same cycle makes room and the write is accepted.
REQ-019 SHALL ignore rd_ready when the FIFO is empty.
REQ-020 SHALL keep rd_data stable while rd_valid is high and rd_ready is low.
REQ-021 SHALL wrap the FIFO pointers modulo FIFO_DEPTH, and fifo_count SHALL reach FIFO_DEPTH exactly when the FIFO is full.

Reset
REQ-022 SHALL, while reset is high, set the state to IDLE, the FIFO empty, fifo_count=0, rd_valid=0, and all error pulses=0, discarding any frame in progress mid-reception, with rd_data don't-care.

Configuration
REQ-023 SHALL use the macro MFP_UART_RX_PARITY_EN to control the parity feature:
- Defined: the PARITY state samples one bit after DATA; parity_error pulses when (XOR of the data bits XOR the parity bit) != parity_odd; the parity_odd and parity_error ports exist.
- Undefined: there is no PARITY state, DATA goes directly to STOP, and the parity ports are absent.

Structure
REQ-024 SHALL place the state-encoding typedef, the oversample constant 16 and the sample-point constants 7/8/9 in the shared package mfp_uart_pkg.
REQ-025 SHALL implement the FIFO as the sub-module mfp_uart_rx_fifo, parametrised by width and depth.

Verification
REQ-026 SHALL cover these directed scenarios with the defaults (DIV=27):
- Valid frame: send 0xA5 with 1 stop bit -> rd_data=0xA5, rd_valid rises 1 clock after tick 9 of the stop bit, no error pulses.
- Glitch: hold rx low for 4*DIV clocks, then high -> no FIFO write, the state machine returns to IDLE, and the next valid frame 0x3C is received correctly.
- Framing error: send 0x55 with the stop bit low -> 0x55 is written, framing_error pulses once, break_detect stays 0.
- Break: hold rx low for 12 bit times -> break_detect and framing_error pulse together, fifo_count is unchanged.
- Overrun: send 9 frames 0x01..0x09 with rd_ready=0 -> fifo_count=8, overrun pulses once on the 9th frame, pops return 0x01..0x08.
- Parity (macro defined, parity_odd=0): send 0x07 with parity bit 1 -> no error; send 0x07 with parity bit 0 -> parity_error pulses.

Source files
------------

// File: rtl/mfp_uart_pkg.sv
// Shared definitions for the parameterised UART receiver.
// Holds the receiver state encoding, the 16x oversample ratio and the
// three sample points used for majority voting within each bit period.
package mfp_uart_pkg;

    localparam int unsigned OS_RATE  = 16;
    localparam int unsigned OS_W     = 4;
    localparam int unsigned SAMPLE_A = 7;
    localparam int unsigned SAMPLE_B = 8;
    localparam int unsigned SAMPLE_C = 9;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_t;

    // 2-of-3 majority vote
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/mfp_uart_rx_fifo.sv
// Receive FIFO for the UART receiver: power-of-two depth, pointers wrap
// naturally. A push that finds the FIFO full is dropped (overrun pulse)
// unless a pop in the same cycle frees an entry.
// Ports:
//   clock, reset         - clock, synchronous active-high reset
//   wr_en, wr_data       - push request and payload
//   rd_ready             - pop the head when rd_valid is high
//   rd_data, rd_valid    - head entry and not-empty flag
//   count                - occupied entries (reaches DEPTH when full)
//   overrun              - one-cycle pulse: a push was dropped
module mfp_uart_rx_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      wr_en,
    input  logic [WIDTH-1:0]          wr_data,
    input  logic                      rd_ready,
    output logic [WIDTH-1:0]          rd_data,
    output logic                      rd_valid,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      overrun
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             pop_c;
    logic             push_c;
    logic             full_c;
    logic [CW-1:0]    next_count_c;

    assign full_c       = (count == CW'(DEPTH));
    assign pop_c        = rd_ready && rd_valid;
    assign push_c       = wr_en && (!full_c || pop_c);
    assign next_count_c = count + CW'(push_c) - CW'(pop_c);
    assign rd_data      = mem[rd_ptr];

    // Storage array, no reset needed
    always_ff @(posedge clock) begin
        if (push_c) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers, occupancy and status
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rd_valid <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count    <= next_count_c;
            rd_valid <= (next_count_c != '0);
            overrun  <= wr_en && !push_c;
        end
    end

endmodule

// File: rtl/mfp_uart_rx_param.sv
// Parameterised UART receiver with 16x oversampling, 2-of-3 majority
// sampling at ticks 7/8/9, start-bit glitch rejection, framing/break
// detection and a receive FIFO.
// Optional parity: define MFP_UART_RX_PARITY_EN to add the PARITY state
// and the parity_odd / parity_error ports.
// Ports:
//   clock, reset        - clock, synchronous active-high reset
//   rx                  - asynchronous serial input, idle high
//   rd_data, rd_valid   - FIFO head (LSB first received), not-empty
//   rd_ready            - pop request
//   fifo_count          - FIFO occupancy
//   framing_error       - pulse: a stop bit sampled low
//   break_detect        - pulse: data bits and first stop bit all low
//   overrun             - pulse: frame dropped, FIFO full
//   parity_odd          - parity select, 1 = odd (parity build only)
//   parity_error        - pulse: parity mismatch (parity build only)
module mfp_uart_rx_param
    import mfp_uart_pkg::*;
#(
    parameter int unsigned CLOCK_FREQUENCY = 50000000,
    parameter int unsigned BAUD_RATE       = 115200,
    parameter int unsigned DATA_BITS       = 8,
    parameter int unsigned STOP_BITS       = 1,
    parameter int unsigned FIFO_DEPTH      = 8
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           rx,
    output logic [DATA_BITS-1:0]           rd_data,
    output logic                           rd_valid,
    input  logic                           rd_ready,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_count,
    output logic                           framing_error,
    output logic                           break_detect,
    output logic                           overrun
`ifdef MFP_UART_RX_PARITY_EN
    ,
    input  logic                           parity_odd,
    output logic                           parity_error
`endif
);

    localparam int unsigned DIV   = CLOCK_FREQUENCY / (BAUD_RATE * OS_RATE);
    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned BIT_W = $clog2(DATA_BITS);

    rx_state_t            state;
    logic                 rx_meta;
    logic                 rx_sync;
    logic                 rx_prev;
    logic [DIV_W-1:0]     div_cnt;
    logic [OS_W-1:0]      os_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic                 stop_idx;
    logic                 stop_err;
    logic                 break_wait;
    logic                 s_a;
    logic                 s_b;
    logic [DATA_BITS-1:0] shift_q;
`ifdef MFP_UART_RX_PARITY_EN
    logic                 par_bit;
`endif

    logic tick_c;
    logic start_edge_c;
    logic sample_c;
    logic maj_c;
    logic last_stop_c;
    logic is_break_c;
    logic wr_en_c;

    // Two-flop synchroniser plus a delayed copy for edge detection
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // After a break the line must return high before a new edge counts
    assign start_edge_c = (state == ST_IDLE) && !break_wait && rx_prev && !rx_sync;
    assign tick_c       = (div_cnt == DIV_W'(DIV - 1));
    assign sample_c     = tick_c && (os_cnt == OS_W'(SAMPLE_C));
    assign maj_c        = maj3(s_a, s_b, rx_sync);
    assign last_stop_c  = (STOP_BITS == 1) || stop_idx;
    assign is_break_c   = (state == ST_STOP) && sample_c && !stop_idx &&
                          (shift_q == '0) && !maj_c;
    assign wr_en_c      = (state == ST_STOP) && sample_c && last_stop_c && !is_break_c;

    // Oversample divider: free-running, realigned to the start edge
    always_ff @(posedge clock) begin
        if (reset || start_edge_c || tick_c) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Receive state machine; bit decisions are taken at tick 9
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= ST_IDLE;
            os_cnt        <= '0;
            bit_cnt       <= '0;
            stop_idx      <= 1'b0;
            stop_err      <= 1'b0;
            break_wait    <= 1'b0;
            s_a           <= 1'b1;
            s_b           <= 1'b1;
            shift_q       <= '0;
            framing_error <= 1'b0;
            break_detect  <= 1'b0;
`ifdef MFP_UART_RX_PARITY_EN
            par_bit       <= 1'b0;
            parity_error  <= 1'b0;
`endif
        end else begin
            framing_error <= 1'b0;
            break_detect  <= 1'b0;
`ifdef MFP_UART_RX_PARITY_EN
            parity_error  <= 1'b0;
`endif
            if ((state != ST_IDLE) && tick_c) begin
                os_cnt <= (os_cnt == OS_W'(OS_RATE - 1)) ? '0 : os_cnt + OS_W'(1);
                if (os_cnt == OS_W'(SAMPLE_A)) s_a <= rx_sync;
                if (os_cnt == OS_W'(SAMPLE_B)) s_b <= rx_sync;
            end

            case (state)
                ST_IDLE: begin
                    if (break_wait && rx_sync) begin
                        break_wait <= 1'b0;
                    end
                    if (start_edge_c) begin
                        state  <= ST_START;
                        os_cnt <= '0;
                    end
                end
                ST_START: begin
                    if (sample_c) begin
                        state   <= maj_c ? ST_IDLE : ST_DATA;
                        bit_cnt <= '0;
                    end
                end
                ST_DATA: begin
                    if (sample_c) begin
                        shift_q <= {maj_c, shift_q[DATA_BITS-1:1]};
                        if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
`ifdef MFP_UART_RX_PARITY_EN
                            state <= ST_PARITY;
`else
                            state <= ST_STOP;
`endif
                            stop_idx <= 1'b0;
                            stop_err <= 1'b0;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end
                    end
                end
`ifdef MFP_UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (sample_c) begin
                        par_bit  <= maj_c;
                        state    <= ST_STOP;
                        stop_idx <= 1'b0;
                        stop_err <= 1'b0;
                    end
                end
`endif
                ST_STOP: begin
                    if (sample_c) begin
                        if (is_break_c) begin
                            framing_error <= 1'b1;
                            break_detect  <= 1'b1;
                            break_wait    <= 1'b1;
                            state         <= ST_IDLE;
                        end else if (last_stop_c) begin
                            framing_error <= stop_err || !maj_c;
`ifdef MFP_UART_RX_PARITY_EN
                            parity_error  <= ((^shift_q) ^ par_bit) != parity_odd;
`endif
                            state         <= ST_IDLE;
                        end else begin
                            // A low first stop bit is flagged once, at the frame write
                            stop_err <= !maj_c;
                            stop_idx <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    mfp_uart_rx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .wr_en    (wr_en_c),
        .wr_data  (shift_q),
        .rd_ready (rd_ready),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .count    (fifo_count),
        .overrun  (overrun)
    );

endmodule
